// File: rtl/addac_vec_recorder.sv
// addac_vec_recorder: records 19-bit addac test vectors {a,b,c,d,e,saida1,saida2}
// into a circular buffer while in RECORD, and lets them be popped in any state.
// FSM: IDLE -> RECORD (start) -> DRAIN (stop) -> IDLE (buffer empty, done pulse).
// Optional macro ADDAC_REC_WRAP_EN: when defined, a capture into a full buffer
// overwrites the oldest word; when undefined, such a capture is dropped.
module addac_vec_recorder #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     cap_en,
  input  logic                     a,
  input  logic                     b,
  input  logic                     e,
  input  logic [3:0]               c,
  input  logic [3:0]               d,
  input  logic [3:0]               saida1,
  input  logic [3:0]               saida2,
  input  logic                     rd_en,
  output logic [18:0]              rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              vec_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECORD, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [18:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [15:0]      vec_count_q, vec_count_d;
  logic             overflow_q, overflow_d;
  logic [18:0]      rd_data_q;
  logic             rd_valid_q;

  logic [18:0]      cap_word;
  logic             cap, pop, wr_ok, rd_adv, lost, arm;

  assign cap_word = {a, b, c, d, e, saida1, saida2};
  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL_LVL);
  assign cap      = (state_q == RECORD) && cap_en;
  assign pop      = rd_en && !empty;
  assign lost     = cap && full && !pop;
  assign arm      = (state_q == IDLE) && start;

`ifdef ADDAC_REC_WRAP_EN
  // Full-buffer capture overwrites the oldest word: write and advance read side.
  assign wr_ok  = cap;
  assign rd_adv = pop || lost;
`else
  // Full-buffer capture without a simultaneous pop is dropped.
  assign wr_ok  = cap && (!full || pop);
  assign rd_adv = pop;
`endif

  // Next-state for FSM; done marks the cycle in which DRAIN retires to IDLE.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = RECORD;
      RECORD:  if (stop)  state_d = DRAIN;
      DRAIN:   if (empty) begin
                 state_d = IDLE;
                 done    = 1'b1;
               end
      default: state_d = IDLE;
    endcase
  end

  // Next-state for pointers, occupancy and sticky status.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    vec_count_d = vec_count_q;
    overflow_d  = overflow_q;
    if (wr_ok)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_adv) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_ok && !rd_adv)      level_d = level_q + (AW+1)'(1);
    else if (rd_adv && !wr_ok) level_d = level_q - (AW+1)'(1);
    if (wr_ok && vec_count_q != 16'hFFFF) vec_count_d = vec_count_q + 16'd1;
    if (lost) overflow_d = 1'b1;
    // start only arrives here in IDLE, where no capture can coincide
    if (arm) begin
      vec_count_d = '0;
      overflow_d  = 1'b0;
    end
  end

  // Control/status registers with synchronous reset; reset discards stored data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      vec_count_q <= '0;
      overflow_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      vec_count_q <= vec_count_d;
      overflow_q  <= overflow_d;
      rd_valid_q  <= pop;
      if (pop) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage array; old read data is taken before a same-cycle overwrite lands.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem_q[wr_ptr_q] <= cap_word;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign vec_count = vec_count_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_addac_vec_recorder.sv
// Bench for addac_vec_recorder: directed scenarios plus random traffic, checked
// against a queue-based reference model; popped words go through a scoreboard
// that a separate monitor drains whenever rd_valid is seen.
module tb_addac_vec_recorder;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int S_IDLE = 0, S_REC = 1, S_DRAIN = 2;
`ifdef ADDAC_REC_WRAP_EN
  localparam int EXP_VC17 = 17;
`else
  localparam int EXP_VC17 = 16;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, stop = 1'b0, cap_en = 1'b0, rd_en = 1'b0;
  logic a = 1'b0, b = 1'b0, e = 1'b0;
  logic [3:0] c = '0, d = '0, saida1 = '0, saida2 = '0;
  logic [18:0] rd_data;
  logic rd_valid, empty, full, overflow, busy, done;
  logic [LW-1:0] level;
  logic [15:0] vec_count;

  int errors = 0, checks = 0;
  logic [18:0] mq[$];     // model contents, oldest first
  logic [18:0] sb[$];     // expected popped words, in order
  logic [18:0] mon_last = '0;
  int mstate = S_IDLE, mcount = 0;
  bit movf = 1'b0;

  always #5 clk = ~clk;

  addac_vec_recorder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cap_en(cap_en),
    .a(a), .b(b), .e(e), .c(c), .d(d), .saida1(saida1), .saida2(saida2),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .level(level), .overflow(overflow), .busy(busy), .done(done),
    .vec_count(vec_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    chk("level", 32'(level), mq.size());
    chk("empty", 32'(empty), mq.size() == 0);
    chk("full", 32'(full), mq.size() == DEPTH);
    chk("overflow", 32'(overflow), movf);
    chk("vec_count", 32'(vec_count), mcount);
    chk("busy", 32'(busy), mstate != S_IDLE);
    chk("done", 32'(done), (mstate == S_DRAIN) && (mq.size() == 0));
  endtask

  // Drive one cycle of inputs and advance the model by the effect of the next edge.
  task automatic step(input bit rs, input bit st, input bit sp, input bit ce,
                      input bit re, input logic [18:0] v);
    int n0;
    bit capv, popv;
    @(negedge clk);
    check_status();
    reset = rs; start = st; stop = sp; cap_en = ce; rd_en = re;
    {a, b, c, d, e, saida1, saida2} = v;
    if (rs) begin
      mq.delete(); sb.delete();
      mstate = S_IDLE; mcount = 0; movf = 1'b0; mon_last = '0;
      return;
    end
    n0   = mq.size();
    capv = (mstate == S_REC) && ce;
    popv = re && (n0 > 0);
    if (popv) sb.push_back(mq.pop_front());
    if (capv) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(v);
        if (mcount < 65535) mcount++;
      end else begin
        movf = 1'b1;
`ifdef ADDAC_REC_WRAP_EN
        mq.delete(0);
        mq.push_back(v);
        if (mcount < 65535) mcount++;
`endif
      end
    end
    case (mstate)
      S_IDLE:  if (st) begin mstate = S_REC; mcount = 0; movf = 1'b0; end
      S_REC:   if (sp) mstate = S_DRAIN;
      default: if (n0 == 0) mstate = S_IDLE;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 3; i++) step(0, 0, 0, 0, 1, '0);
    idle(2);
  endtask

  // Monitor: every cycle, compare registered read outputs with the scoreboard.
  initial begin
    logic [18:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_valid_spurious: got rd_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          exp_v = sb.pop_front();
          chk("rd_data", 32'(rd_data), 32'(exp_v));
          mon_last = exp_v;
        end
      end else begin
        if (sb.size() != 0) begin
          chk("rd_valid", 32'(rd_valid), 32'd1);
          exp_v = sb.pop_front();
          mon_last = exp_v;
        end else begin
          chk("rd_hold", 32'(rd_data), 32'(mon_last));
        end
      end
    end
  end

  initial begin
    logic [18:0] v;
    bit rs;
    // Reset state
    step(1, 0, 0, 0, 0, '0);
    step(1, 0, 1, 1, 1, '0);
    @(posedge clk); #2;
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_vec_count", 32'(vec_count), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // Single vector round trip, then done pulse back to IDLE
    step(0, 1, 0, 0, 0, '0);
    step(0, 0, 0, 1, 0, {1'b1, 1'b0, 4'b0011, 4'b0101, 1'b1, 4'b1000, 4'b0001});
    step(0, 0, 1, 0, 0, '0);
    step(0, 0, 0, 0, 1, '0);
    @(posedge clk); #2;
    chk("single_rd_data", 32'(rd_data), 32'(19'b1_0_0011_0101_1_1000_0001));
    chk("single_rd_valid", 32'(rd_valid), 1);
    idle(3);

    // Read while empty
    step(0, 0, 0, 0, 1, '0);
    idle(1);

    // Capture strobe in IDLE is ignored
    step(0, 0, 0, 1, 0, 19'h5A5A5);
    idle(1);

    // 17 captures into a 16-deep buffer
    step(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 17; i++) begin
      v = 19'h12345;
      v[11:8] = 4'(i);
      step(0, 0, 0, 1, 0, v);
    end
    idle(1);
    @(posedge clk); #2;
    chk("ovf17_full", 32'(full), 1);
    chk("ovf17_overflow", 32'(overflow), 1);
    chk("ovf17_vec_count", 32'(vec_count), EXP_VC17);
    step(0, 0, 1, 0, 0, '0);
    drain();

    // Full buffer with simultaneous capture and pop
    step(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0, 19'($urandom));
    step(0, 0, 0, 1, 1, 19'h7FFFF);
    idle(1);
    @(posedge clk); #2;
    chk("fullrw_level", 32'(level), DEPTH);
    chk("fullrw_overflow", 32'(overflow), 0);
    // Capture strobe in DRAIN is ignored
    step(0, 0, 1, 0, 0, '0);
    step(0, 0, 0, 1, 0, 19'h00F0F);
    step(0, 0, 0, 1, 0, 19'h0F0F0);
    drain();

    // Reset in RECORD with 5 stored words
    step(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 19'($urandom));
    step(1, 0, 0, 1, 0, 19'h11111);
    @(posedge clk); #2;
    chk("rstrec_level", 32'(level), 0);
    chk("rstrec_empty", 32'(empty), 1);
    chk("rstrec_busy", 32'(busy), 0);
    chk("rstrec_rd_valid", 32'(rd_valid), 0);

    // Random traffic; read rate is low in the first half so the buffer fills
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(199) == 0);
      if (rs) step(1, 0, 0, 0, 0, '0);
      else step(0, $urandom_range(19) == 0, $urandom_range(24) == 0,
                $urandom_range(9) < 6,
                $urandom_range(9) < ((i < 1500) ? 2 : 5), 19'($urandom));
    end
    step(0, 0, 1, 0, 0, '0);
    drain();
    idle(2);
    @(posedge clk); #2;
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/addac_vec_recorder.md
ADDAC_VEC_RECORDER -- requirements
Module: addac_vec_recorder

Interface
REQ-001 SHALL have parameter DEPTH, default 16 (power of two, >=4), the vector storage depth in words.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; arm recording.
- stop  in  1  pulse; end recording.
- cap_en  in  1  capture strobe for current sample.
- a, b, e  in  1 each  addac DUV inputs.
- c, d  in  4 each  addac DUV inputs.
- saida1, saida2  in  4 each  addac DUV outputs.
- rd_en  in  1  pop request.
- rd_data  out  19  popped vector.
- rd_valid  out  1  rd_data valid this cycle.
- empty, full  out  1 each  storage status.
- level  out  $clog2(DEPTH)+1  words stored.
- overflow  out  1  sticky: a capture was lost or overwrote data.
- busy  out  1  high in RECORD or DRAIN.
- done  out  1  one-cycle pulse on DRAIN->IDLE.
- vec_count  out  16  captures accepted since start, saturating at 16'hFFFF.

Function
REQ-003 SHALL pack each capture MSB-first as {a, b, c, d, e, saida1, saida2}: a = bit 18, saida2 = bits 3:0, matching the 19-bit tabela-addac.tv line format.
REQ-004 SHALL implement FSM IDLE, RECORD, DRAIN. IDLE->RECORD on start. RECORD->DRAIN on stop. DRAIN->IDLE when empty, with done high for that one cycle.
REQ-005 start in IDLE SHALL clear vec_count and overflow, but not stored data. start outside IDLE SHALL be ignored. stop outside RECORD SHALL be ignored.
REQ-006 A capture SHALL occur only when state is RECORD and cap_en=1. Sampling happens on the same edge, so data is stored and level is updated on the next cycle.
REQ-007 A pop SHALL occur when rd_en=1 and empty=0, in any state. rd_data and rd_valid are registered: valid exactly 1 cycle after the accepting rd_en. rd_en when empty SHALL give rd_valid=0 and leave rd_data unchanged.
REQ-008 A simultaneous capture and pop SHALL both take effect, with level unchanged. This includes when full.
REQ-009 When full, a capture with no pop in the same cycle SHALL follow REQ-015, and overflow SHALL be set.
REQ-010 Read and write pointers SHALL wrap modulo DEPTH. level SHALL equal DEPTH exactly when full=1, and 0 exactly when empty=1.
REQ-011 vec_count SHALL increment on every accepted capture, including overwrites, and SHALL saturate.
REQ-012 start and stop asserted in the same cycle SHALL act on start only if in IDLE, and on stop only if in RECORD (their states are mutually exclusive).

Reset
REQ-013 On reset=1 at a clk edge, the block SHALL go to IDLE, with pointers=0, level=0, empty=1, full=0, rd_valid=0, rd_data=0, overflow=0, busy=0, done=0, vec_count=0.
REQ-014 Reset SHALL take priority over every other input, including mid-RECORD and mid-DRAIN. All stored vectors SHALL be discarded.

Configuration
REQ-015 Macro ADDAC_REC_WRAP_EN:
- Defined: a capture when full SHALL overwrite the oldest word and advance the read pointer. level stays DEPTH.
- Undefined: a capture when full SHALL be dropped and storage left unchanged.
- In both cases overflow SHALL be set and vec_count counts only stored captures. Undefined: a dropped capture SHALL not increment vec_count.

Verification
REQ-016 start, then one capture with a=1, b=0, c=4'b0011, d=4'b0101, e=1, saida1=4'b1000, saida2=4'b0001, then stop, then rd_en -> rd_data=19'b1_0_0011_0101_1_1000_0001 one cycle later with rd_valid=1, then done pulse, then IDLE.
REQ-017 DEPTH=16, 17 consecutive captures with c=0..16 (mod 16), no reads:
- Undefined macro: full=1, overflow=1, vec_count=16; reads return c=0..15.
- Defined macro: vec_count=17; the first read returns c=1.
REQ-018 full, capture and rd_en in the same cycle -> level stays 16, overflow stays 0, oldest word returned.
REQ-019 rd_en while empty -> rd_valid=0, rd_data holds its previous value, level stays 0.
REQ-020 reset asserted in RECORD with level=5 -> next cycle IDLE, level=0, empty=1, busy=0, rd_valid=0.
REQ-021 cap_en=1 in IDLE or DRAIN -> no capture; level and vec_count unchanged.
